// File: rtl/cpu_types_pkg.sv
// Shared CPU cache types.
// Holds the instruction-cache frame layout and the address-split layout.
// Both are sized for the default 16-frame geometry. Modules built with another
// frame count derive their own widths locally.
package cpu_types_pkg;

    localparam int IIDX_W = 4;
    localparam int ITAG_W = 32 - IIDX_W - 2;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        logic [31:0]       data;
    } icache_frame_t;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache.
//   CLK, RST       : clock, synchronous active-high reset
//   imemREN, imemaddr, halt -> ihit, imemload   : datapath side
//   iREN, iaddr -> iwait, iload                 : memory side
//   hit_count, miss_count                       : saturating performance counters
// A miss holds FETCH until memory drops iwait. The fill is written on that edge,
// and the hit appears on the following cycle. If the datapath drops the request
// or halts mid-fetch, the fetch is abandoned with no fill.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        halt,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int IW = $clog2(SETS);
    localparam int TW = 30 - IW;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t state, nxt;

    logic          valid [SETS];
    logic [TW-1:0] tags  [SETS];
    logic [31:0]   data  [SETS];

    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic          req, hit, fill, miss;
    logic          unused_bytoff;

    assign idx           = imemaddr[IW+1:2];
    assign tag           = imemaddr[31:IW+2];
    assign unused_bytoff = ^imemaddr[1:0];

    // RST is folded into req. This keeps every output low during the reset cycle.
    assign req = imemREN && !halt && !RST;
    assign hit = (state == IDLE) && req && valid[idx] && (tags[idx] == tag);

    assign ihit     = hit;
    assign imemload = hit ? data[idx] : 32'h0;
    assign iaddr    = iREN ? imemaddr : 32'h0;

    always_comb begin
        nxt  = state;
        iREN = 1'b0;
        fill = 1'b0;
        miss = 1'b0;
        case (state)
            IDLE: begin
                if (req && !hit) begin
                    nxt  = FETCH;
                    miss = 1'b1;
                end
            end
            FETCH: begin
                if (!req) begin
                    nxt = IDLE;            // abandoned: no fill
                end else begin
                    iREN = 1'b1;
                    if (!iwait) begin
                        fill = 1'b1;
                        nxt  = IDLE;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            hit_count  <= '0;
            miss_count <= '0;
            for (int i = 0; i < SETS; i++) begin
                valid[i] <= 1'b0;
                tags[i]  <= '0;
                data[i]  <= '0;
            end
        end else begin
            state <= nxt;
            if (fill) begin
                valid[idx] <= 1'b1;
                tags[idx]  <= tag;
                data[idx]  <= iload;
            end
            if (hit && hit_count != 32'hFFFF_FFFF)
                hit_count <= hit_count + 32'd1;
            if (miss && miss_count != 32'hFFFF_FFFF)
                miss_count <= miss_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_icache.sv
module tb_icache;

    logic        CLK = 1'b0;
    logic        RST, imemREN, halt, iwait;
    logic [31:0] imemaddr, iload;
    logic        ihit, iREN;
    logic [31:0] imemload, iaddr, hit_count, miss_count;

    icache #(.SETS(16)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .halt(halt),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: a word store keyed by index, plus a pending-miss flag.
    bit          mv [16];
    logic [25:0] mt [16];
    logic [31:0] md [16];
    bit          pending;
    logic [31:0] mhc, mmc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            mv[i] = 0; mt[i] = '0; md[i] = '0;
        end
        pending = 0; mhc = '0; mmc = '0;
    endtask

    // One clock: drive, compare at negedge against the model, then advance the model.
    task automatic step(input bit r, input bit ren, input logic [31:0] a, input bit h,
                        input bit w, input logic [31:0] ld,
                        output bit ohit, output bit oiren, output logic [31:0] oload,
                        output logic [31:0] ohc, output logic [31:0] omc);
        int          i;
        logic [25:0] t;
        bit          active, xh, xr;
        RST = r; imemREN = ren; imemaddr = a; halt = h; iwait = w; iload = ld;
        i = int'(a[5:2]);
        t = a[31:6];
        active = !r && ren && !h;
        xh = active && !pending && mv[i] && mt[i] == t;
        xr = active && pending;
        @(negedge CLK);
        chk("ihit", 32'(ihit), 32'(xh));
        chk("imemload", imemload, xh ? md[i] : 32'h0);
        chk("iREN", 32'(iREN), 32'(xr));
        chk("iaddr", iaddr, xr ? a : 32'h0);
        chk("hit_count", hit_count, mhc);
        chk("miss_count", miss_count, mmc);
        ohit = ihit; oiren = iREN; oload = imemload; ohc = hit_count; omc = miss_count;
        @(posedge CLK);
        if (r) model_clear();
        else if (!pending) begin
            if (xh) begin
                if (mhc != 32'hFFFF_FFFF) mhc++;
            end else if (active) begin
                pending = 1;
                if (mmc != 32'hFFFF_FFFF) mmc++;
            end
        end else if (!active) pending = 0;
        else if (!w) begin
            mv[i] = 1; mt[i] = t; md[i] = ld; pending = 0;
        end
        #1;
    endtask

    typedef struct {
        bit          rst, ren;
        logic [31:0] addr;
        bit          h, w;
        logic [31:0] ld;
        bit          xhit, xiren;
        logic [31:0] xload, xhc, xmc;
    } vec_t;

    vec_t        tbl [11];
    bit          oh, ori;
    logic [31:0] ol, ohc, omc, hc0;
    int          iren_cycles;

    initial begin
        RST = 1; imemREN = 0; imemaddr = 0; halt = 0; iwait = 1; iload = 0;
        model_clear();
        @(posedge CLK); #1;

        // Cold miss (3 wait cycles), two hits, then halt blocks both hit and miss.
        tbl[0]  = '{1, 0, 32'h40, 0, 1, 0,            0, 0, 32'h0,        0, 0};
        tbl[1]  = '{0, 1, 32'h40, 0, 1, 0,            0, 0, 32'h0,        0, 0};
        tbl[2]  = '{0, 1, 32'h40, 0, 1, 0,            0, 1, 32'h0,        0, 1};
        tbl[3]  = '{0, 1, 32'h40, 0, 1, 0,            0, 1, 32'h0,        0, 1};
        tbl[4]  = '{0, 1, 32'h40, 0, 1, 0,            0, 1, 32'h0,        0, 1};
        tbl[5]  = '{0, 1, 32'h40, 0, 0, 32'h8C220004, 0, 1, 32'h0,        0, 1};
        tbl[6]  = '{0, 1, 32'h40, 0, 1, 0,            1, 0, 32'h8C220004, 0, 1};
        tbl[7]  = '{0, 1, 32'h40, 0, 1, 0,            1, 0, 32'h8C220004, 1, 1};
        tbl[8]  = '{0, 1, 32'h80, 1, 1, 0,            0, 0, 32'h0,        2, 1};
        tbl[9]  = '{0, 1, 32'h40, 1, 1, 0,            0, 0, 32'h0,        2, 1};
        tbl[10] = '{0, 0, 32'h40, 0, 1, 0,            0, 0, 32'h0,        2, 1};
        iren_cycles = 0;
        for (int k = 0; k < 11; k++) begin
            step(tbl[k].rst, tbl[k].ren, tbl[k].addr, tbl[k].h, tbl[k].w, tbl[k].ld,
                 oh, ori, ol, ohc, omc);
            if (ori) iren_cycles++;
            chk($sformatf("vec%0d.ihit", k), 32'(oh), 32'(tbl[k].xhit));
            chk($sformatf("vec%0d.iREN", k), 32'(ori), 32'(tbl[k].xiren));
            chk($sformatf("vec%0d.imemload", k), ol, tbl[k].xload);
            chk($sformatf("vec%0d.hits", k), ohc, tbl[k].xhc);
            chk($sformatf("vec%0d.misses", k), omc, tbl[k].xmc);
        end
        chk("cold_iren_cycles", 32'(iren_cycles), 32'd4);

        // Hit reuse: ten back-to-back hits.
        step(0, 0, 32'h40, 0, 1, 0, oh, ori, ol, hc0, omc);
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 32'h40, 0, 1, 0, oh, ori, ol, ohc, omc);
            chk("reuse_hit", 32'(oh), 32'd1);
        end
        step(0, 0, 32'h40, 0, 1, 0, oh, ori, ol, ohc, omc);
        chk("reuse_count", ohc, hc0 + 32'd10);

        // Conflict at index 0: 0x440 evicts 0x40, so 0x40 misses again.
        step(0, 1, 32'h440, 0, 1, 0, oh, ori, ol, ohc, omc);
        chk("conflict_miss", 32'(oh), 32'd0);
        step(0, 1, 32'h440, 0, 0, 32'hDEAD0440, oh, ori, ol, ohc, omc);
        step(0, 1, 32'h440, 0, 1, 0, oh, ori, ol, ohc, omc);
        chk("conflict_hitdata", ol, 32'hDEAD0440);
        step(0, 1, 32'h40, 0, 1, 0, oh, ori, ol, ohc, omc);
        chk("evicted_miss", 32'(oh), 32'd0);
        step(0, 1, 32'h40, 0, 0, 32'h0BAD0040, oh, ori, ol, ohc, omc);
        chk("conflict_misses", omc, 32'd3);

        // Abort: drop imemREN mid-fetch; the same address misses later.
        step(0, 1, 32'h84, 0, 1, 0, oh, ori, ol, ohc, omc);
        step(0, 1, 32'h84, 0, 1, 0, oh, ori, ol, ohc, omc);
        chk("abort_pre_iren", 32'(ori), 32'd1);
        step(0, 0, 32'h84, 0, 0, 32'h12345678, oh, ori, ol, ohc, omc);
        chk("abort_iren", 32'(ori), 32'd0);
        step(0, 1, 32'h84, 0, 1, 0, oh, ori, ol, ohc, omc);
        chk("abort_remiss", 32'(oh | ori), 32'd0);
        step(0, 1, 32'h84, 0, 0, 32'hCAFE0084, oh, ori, ol, ohc, omc);
        chk("abort_refetch", 32'(ori), 32'd1);

        // Reset mid-fetch.
        step(0, 1, 32'hC0, 0, 1, 0, oh, ori, ol, ohc, omc);
        step(0, 1, 32'hC0, 0, 1, 0, oh, ori, ol, ohc, omc);
        step(1, 1, 32'hC0, 0, 0, 32'h55555555, oh, ori, ol, ohc, omc);
        chk("rst_iren", 32'(ori), 32'd0);
        step(0, 1, 32'h40, 0, 1, 0, oh, ori, ol, ohc, omc);
        chk("rst_frame_invalid", 32'(oh), 32'd0);
        chk("rst_hits", ohc, 32'd0);
        chk("rst_misses", omc, 32'd0);
        step(0, 0, 32'h0, 0, 1, 0, oh, ori, ol, ohc, omc);

        // Randomized traffic over a small, conflict-heavy address pool.
        for (int k = 0; k < 800; k++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 2);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 90, a,
                 $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 40, $urandom,
                 oh, ori, ol, ohc, omc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
